// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int ARB_NREQ  = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Encode a one-hot vector to its bit index. The arbiter only feeds this
  // a one-hot grant, so OR-ing the indices of the set bits gives the
  // index directly.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(
    input logic [ARB_NREQ-1:0] oh
  );
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_NREQ; i++) begin
      if (oh[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational circular priority search: returns the one-hot position of
// the first set bit of req, starting at ptr and wrapping 7 -> 0.
// Rotates req down by ptr, isolates the lowest set bit, and rotates back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_NREQ-1:0]  req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic [ARB_NREQ-1:0]  pick
);

  logic [ARB_NREQ-1:0] w_rot;
  logic [ARB_NREQ-1:0] w_ffs;

  // Rotate requests so the pointed-to requester sits at bit 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_rot = '0;
    for (int j = 0; j < ARB_NREQ; j++) begin
      w_rot[j] = req[ARB_IDX_W'(j + int'(ptr))];
    end
  end

  // Isolate the lowest set bit (two's-complement trick); zero stays zero.
  assign w_ffs = w_rot & (~w_rot + 8'd1);

  // Rotate the isolated bit back to its original requester position.
  always_comb begin
    pick = '0;
    for (int m = 0; m < ARB_NREQ; m++) begin
      pick[m] = w_ffs[ARB_IDX_W'(m - int'(ptr))];
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters. Registered one-hot grant with
// hold until req drop / done / hold limit, a mandatory idle cycle between
// grants, and a one-cycle timeout pulse when the hold limit alone forced
// the release.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16  // legal 2..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [ARB_NREQ-1:0]  req,
  input  logic                 done,
  output logic [ARB_NREQ-1:0]  gnt,
  output logic                 gnt_valid,
  output logic                 timeout,
  output logic [ARB_IDX_W-1:0] ptr
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_e           r_state;
  logic [ARB_NREQ-1:0]  r_gnt;
  logic                 r_gnt_valid;
  logic                 r_timeout;
  logic [ARB_IDX_W-1:0] r_ptr;
  logic [7:0]           r_hold_cnt;

  logic [ARB_NREQ-1:0]  w_pick;
  logic [ARB_IDX_W-1:0] w_gnt_idx;
  logic                 w_req_drop;
  logic                 w_limit;
  logic                 w_release;
  logic                 w_limit_only;

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick)
  );

  // Release decode. The holder's request bit is found by masking with the
  // registered grant, so other requesters' activity has no effect here.
  assign w_gnt_idx    = onehot_to_idx(r_gnt);
  assign w_req_drop   = (req & r_gnt) == '0;
  assign w_limit      = (r_hold_cnt == HOLD_LAST);
  assign w_release    = w_req_drop | done | w_limit;
  assign w_limit_only = w_limit & ~done & ~w_req_drop;

  // Arbitration FSM, hold counter, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state, including the counter, is reset so the grant drops
    // the instant rst_n falls, with no clock required.
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      r_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          // en gates only new grants; done is ignored while idle.
          if (en && (w_pick != '0)) begin
            r_gnt       <= w_pick;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= '0;
            r_state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_release) begin
            // Returning to IDLE guarantees one all-zero cycle before the
            // next grant can be registered.
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= w_gnt_idx + 3'd1;
            r_timeout   <= w_limit_only;
            r_state     <= ARB_IDLE;
          end else begin
            r_hold_cnt  <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;
  assign ptr       = r_ptr;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed testbench for rr_arbiter_8 (MAX_HOLD = 4).
`timescale 1ns/1ps
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;
  logic [2:0] ptr;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .ptr       (ptr)
  );

  // Gateable clock so reset can be exercised with the clock stopped.
  always #5 if (clk_run) clk = ~clk;

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    en    = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h expected 00", gnt); end
    checks++;
    if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", gnt_valid); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++;
    if (ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    en  = 1'b1;
    req = 8'h08;
    tick();
    checks++;
    if (gnt !== 8'h08) begin errors++; $display("FAIL midrst_pre_gnt: got %h expected 08", gnt); end
    clk_run = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00) begin errors++; $display("FAIL midrst_async_gnt: got %h expected 00", gnt); end
    checks++;
    if (gnt_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b expected 0", gnt_valid); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ptr !== 3'd0) begin errors++; $display("FAIL midrst_ptr: got %0d expected 0", ptr); end
    clk_run = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h08) begin errors++; $display("FAIL midrst_regrant: got %h expected 08", gnt); end
    req = 8'h00;
    tick();
    checks++;
    if (ptr !== 3'd4) begin errors++; $display("FAIL midrst_release_ptr: got %0d expected 4", ptr); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_g;
    logic [2:0] exp_p;
    apply_reset();
    req = 8'hFF;
    en  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_g = 8'h01 << (i % 8);
      exp_p = 3'((i + 1) % 8);
      tick();
      checks++;
      if (gnt !== exp_g) begin errors++; $display("FAIL rr_grant_%0d: got %h expected %h", i, gnt, exp_g); end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (gnt !== 8'h00) begin errors++; $display("FAIL rr_gap_%0d: got %h expected 00", i, gnt); end
      checks++;
      if (ptr !== exp_p) begin errors++; $display("FAIL rr_ptr_%0d: got %0d expected %0d", i, ptr, exp_p); end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_skip_pattern();
    req = 8'h10;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (ptr !== 3'd5) begin errors++; $display("FAIL skip_setup_ptr: got %0d expected 5", ptr); end
    req = 8'h21;
    tick();
    checks++;
    if (gnt !== 8'h20) begin errors++; $display("FAIL skip_first: got %h expected 20", gnt); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (ptr !== 3'd6) begin errors++; $display("FAIL skip_ptr: got %0d expected 6", ptr); end
    tick();
    checks++;
    if (gnt !== 8'h01) begin errors++; $display("FAIL skip_wrap: got %h expected 01", gnt); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_hold_timeout();
    req = 8'h04;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h04 || timeout !== 1'b0) begin
        errors++; $display("FAIL hold_cycle_%0d: got gnt %h to %b expected gnt 04 to 0", c, gnt, timeout);
      end
    end
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got gnt %h valid %b expected 00 0", gnt, gnt_valid); end
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL hold_timeout_pulse: got %b expected 1", timeout); end
    checks++;
    if (ptr !== 3'd3) begin errors++; $display("FAIL hold_ptr: got %0d expected 3", ptr); end
    tick();
    checks++;
    if (gnt !== 8'h04 || timeout !== 1'b0) begin errors++; $display("FAIL hold_regrant: got gnt %h to %b expected gnt 04 to 0", gnt, timeout); end
    req = 8'h00;
    tick();
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL hold_drop: got gnt %h to %b expected gnt 00 to 0", gnt, timeout); end
  endtask

  task automatic test_simultaneous_release();
    // done and req drop together at the hold limit.
    req = 8'h08;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (gnt !== 8'h08) begin errors++; $display("FAIL simul_held: got %h expected 08", gnt); end
    done = 1'b1;
    req  = 8'h00;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL simul_release: got gnt %h to %b expected gnt 00 to 0", gnt, timeout); end
    checks++;
    if (ptr !== 3'd4) begin errors++; $display("FAIL simul_ptr: got %0d expected 4", ptr); end
    tick();
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0 || ptr !== 3'd4) begin
      errors++; $display("FAIL simul_after: got gnt %h to %b ptr %0d expected 00 0 4", gnt, timeout, ptr);
    end
    // done alone coincides with the limit, request still held.
    req = 8'h10;
    for (int c = 0; c < 4; c++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL done_limit_release: got gnt %h to %b expected gnt 00 to 0", gnt, timeout); end
    checks++;
    if (ptr !== 3'd5) begin errors++; $display("FAIL done_limit_ptr: got %0d expected 5", ptr); end
    tick();
    checks++;
    if (gnt !== 8'h10) begin errors++; $display("FAIL done_limit_regrant: got %h expected 10", gnt); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_enable_gating();
    req = 8'hFF;
    en  = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h20) begin errors++; $display("FAIL en_first: got %h expected 20", gnt); end
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_valid !== 1'b1) begin errors++; $display("FAIL en_keep: got gnt %h valid %b expected 20 1", gnt, gnt_valid); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 8'h00 || ptr !== 3'd6) begin errors++; $display("FAIL en_release: got gnt %h ptr %0d expected 00 6", gnt, ptr); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h00) begin errors++; $display("FAIL en_blocked_%0d: got %h expected 00", c, gnt); end
    end
    en = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h40) begin errors++; $display("FAIL en_resume: got %h expected 40", gnt); end
    req = 8'h00;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    test_reset();
    test_reset_mid_grant();
    test_round_robin();
    test_skip_pattern();
    test_hold_timeout();
    test_simultaneous_release();
    test_enable_gating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
